// File: rtl/matrix_result_writer_if.sv
// Write-request and data-stream handshake between a matrix operation unit
// and matrix_result_writer.
interface matrix_result_writer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  write_request;
    logic                  write_ready;
    logic [2:0]            matrix_id;
    logic [7:0]            actual_rows;
    logic [7:0]            actual_cols;
    logic [7:0]            matrix_name [0:7];
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  writer_ready;
    logic                  write_done;
    logic                  write_error;

    modport master (
        output write_request, matrix_id, actual_rows, actual_cols, matrix_name,
               data_in, data_valid,
        input  write_ready, writer_ready, write_done, write_error
    );

    modport slave (
        input  write_request, matrix_id, actual_rows, actual_cols, matrix_name,
               data_in, data_valid,
        output write_ready, writer_ready, write_done, write_error
    );
endinterface

// File: rtl/matrix_result_writer.sv
// Accepts a matrix write request, writes its metadata header and row-major
// data stream into the selected BRAM block, then pulses write_done.
module matrix_result_writer #(
    parameter int unsigned BLOCK_SIZE = 1024,
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_result_writer_if.slave bus,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data
);
    localparam int unsigned MATRIX_METADATA_WORDS = 3;
    localparam int unsigned ID_W     = 3;
    localparam int unsigned DIM_W    = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned NAME_LEN = 8;

    typedef enum logic [2:0] {IDLE, CHECK, META, DATA, DONE} state_e;

    state_e                state_q, state_d;
    logic                  write_ready_q, write_ready_d;
    logic                  writer_ready_q, writer_ready_d;
    logic                  write_done_q, write_done_d;
    logic                  write_error_q, write_error_d;
    logic                  bram_wr_en_q, bram_wr_en_d;
    logic [ADDR_WIDTH-1:0] bram_wr_addr_q, bram_wr_addr_d;
    logic [DATA_WIDTH-1:0] bram_wr_data_q, bram_wr_data_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DIM_W-1:0]      rows_q, rows_d;
    logic [DIM_W-1:0]      cols_q, cols_d;
    logic [7:0]            name_q [NAME_LEN];
    logic [7:0]            name_d [NAME_LEN];
    logic [CNT_W-1:0]      meta_idx_q, meta_idx_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

    logic [CNT_W-1:0]      total_c;
    logic                  reject_c;
    logic [ADDR_WIDTH-1:0] base_c;
    logic [ADDR_WIDTH-1:0] data_addr_c;
    logic [CNT_W-1:0]      hdr_idx_c;
    logic [DATA_WIDTH-1:0] hdr_word_c;

    // Transaction geometry derived from the latched request
    always_comb begin : geometry
        total_c     = CNT_W'(rows_q) * CNT_W'(cols_q);
        reject_c    = (rows_q == '0) || (cols_q == '0)
                   || (32'(id_q) >= NUM_BLOCKS)
                   || ((32'(total_c) + MATRIX_METADATA_WORDS) > BLOCK_SIZE);
        base_c      = ADDR_WIDTH'(id_q) * ADDR_WIDTH'(BLOCK_SIZE);
        data_addr_c = base_c + ADDR_WIDTH'(MATRIX_METADATA_WORDS) + ADDR_WIDTH'(beat_cnt_q);
    end

    // Index of the header word to be registered on the coming edge
    always_comb begin : header_index
        hdr_idx_c = '0;
        if (state_q == META) begin
            hdr_idx_c = meta_idx_q + CNT_W'(1);
        end
    end

    always_comb begin : header_mux
        hdr_word_c = '0;
        if (hdr_idx_c == CNT_W'(0)) begin
            hdr_word_c = DATA_WIDTH'({rows_q, cols_q, 16'd0});
        end else if (hdr_idx_c == CNT_W'(1)) begin
            hdr_word_c = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
        end else if (hdr_idx_c == CNT_W'(2)) begin
            hdr_word_c = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
        end
    end

    always_comb begin : next_state
        state_d        = state_q;
        write_ready_d  = write_ready_q;
        writer_ready_d = writer_ready_q;
        write_done_d   = 1'b0;
        write_error_d  = 1'b0;
        bram_wr_en_d   = 1'b0;
        bram_wr_addr_d = bram_wr_addr_q;
        bram_wr_data_d = bram_wr_data_q;
        id_d           = id_q;
        rows_d         = rows_q;
        cols_d         = cols_q;
        name_d         = name_q;
        meta_idx_d     = meta_idx_q;
        beat_cnt_d     = beat_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.write_request && write_ready_q) begin
                    id_d          = bus.matrix_id;
                    rows_d        = bus.actual_rows;
                    cols_d        = bus.actual_cols;
                    name_d        = bus.matrix_name;
                    meta_idx_d    = '0;
                    beat_cnt_d    = '0;
                    write_ready_d = 1'b0;
                    state_d       = CHECK;
                end
            end
            CHECK: begin
                if (reject_c) begin
                    write_done_d  = 1'b1;
                    write_error_d = 1'b1;
                    state_d       = DONE;
                end else begin
                    bram_wr_en_d   = 1'b1;
                    bram_wr_addr_d = base_c;
                    bram_wr_data_d = hdr_word_c;
                    state_d        = META;
                end
            end
            META: begin
                // meta_idx_q is the header word currently on the BRAM port
                if (meta_idx_q == CNT_W'(MATRIX_METADATA_WORDS - 1)) begin
                    writer_ready_d = 1'b1;
                    state_d        = DATA;
                end else begin
                    bram_wr_en_d   = 1'b1;
                    bram_wr_addr_d = base_c + ADDR_WIDTH'(hdr_idx_c);
                    bram_wr_data_d = hdr_word_c;
                    meta_idx_d     = hdr_idx_c;
                end
            end
            DATA: begin
                if (bus.data_valid && writer_ready_q) begin
                    bram_wr_en_d   = 1'b1;
                    bram_wr_addr_d = data_addr_c;
                    bram_wr_data_d = bus.data_in;
                    beat_cnt_d     = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == total_c - CNT_W'(1)) begin
                        writer_ready_d = 1'b0;
                        write_done_d   = 1'b1;
                        state_d        = DONE;
                    end
                end
            end
            DONE: begin
                write_ready_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q        <= IDLE;
            write_ready_q  <= 1'b1;
            writer_ready_q <= 1'b0;
            write_done_q   <= 1'b0;
            write_error_q  <= 1'b0;
            bram_wr_en_q   <= 1'b0;
            bram_wr_addr_q <= '0;
            bram_wr_data_q <= '0;
            id_q           <= '0;
            rows_q         <= '0;
            cols_q         <= '0;
            name_q         <= '{default: '0};
            meta_idx_q     <= '0;
            beat_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            write_ready_q  <= write_ready_d;
            writer_ready_q <= writer_ready_d;
            write_done_q   <= write_done_d;
            write_error_q  <= write_error_d;
            bram_wr_en_q   <= bram_wr_en_d;
            bram_wr_addr_q <= bram_wr_addr_d;
            bram_wr_data_q <= bram_wr_data_d;
            id_q           <= id_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            name_q         <= name_d;
            meta_idx_q     <= meta_idx_d;
            beat_cnt_q     <= beat_cnt_d;
        end
    end

    assign bus.write_ready  = write_ready_q;
    assign bus.writer_ready = writer_ready_q;
    assign bus.write_done   = write_done_q;
    assign bus.write_error  = write_error_q;
    assign bram_wr_en       = bram_wr_en_q;
    assign bram_wr_addr     = bram_wr_addr_q;
    assign bram_wr_data     = bram_wr_data_q;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Scoreboard bench for matrix_result_writer: expected BRAM writes and done
// events are queued at issue time and checked by an independent monitor.
module tb_matrix_result_writer;
    localparam int unsigned BLOCK_SIZE = 1024;
    localparam int unsigned NUM_BLOCKS = 8;
    localparam int unsigned ADDR_WIDTH = 14;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned HDR_WORDS  = 3;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int unsigned act;
        int unsigned exp;
    } chk_t;

    logic                  clk;
    logic                  rst;
    logic                  bram_wr_en;
    logic [ADDR_WIDTH-1:0] bram_wr_addr;
    logic [DATA_WIDTH-1:0] bram_wr_data;

    matrix_result_writer_if #(.DATA_WIDTH(DATA_WIDTH)) mif ();

    matrix_result_writer #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .NUM_BLOCKS(NUM_BLOCKS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (mif),
        .bram_wr_en   (bram_wr_en),
        .bram_wr_addr (bram_wr_addr),
        .bram_wr_data (bram_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wr_t  exp_wr[$];
    logic exp_done[$];
    chk_t chk_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    // Monitor: the only process that counts and reports comparisons
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        wr_t  w;
        logic e;
        chk_t c;
        if (bram_wr_en === 1'b1) begin
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_bad++;
                $display("FAIL bram_write: unexpected write addr=%0d data=%08h", bram_wr_addr, bram_wr_data);
            end else begin
                w = exp_wr.pop_front();
                if (bram_wr_addr !== w.addr || bram_wr_data !== w.data) begin
                    n_bad++;
                    $display("FAIL bram_write: got addr=%0d data=%08h expected addr=%0d data=%08h",
                             bram_wr_addr, bram_wr_data, w.addr, w.data);
                end
            end
        end
        if (mif.write_done === 1'b1) begin
            n_cmp++;
            if (exp_done.size() == 0) begin
                n_bad++;
                $display("FAIL write_done: unexpected pulse error=%0b", mif.write_error);
            end else begin
                e = exp_done.pop_front();
                if (mif.write_error !== e) begin
                    n_bad++;
                    $display("FAIL write_error: got %0b expected %0b", mif.write_error, e);
                end
            end
        end
        if (prev_done) begin
            n_cmp++;
            if (mif.write_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL ready_after_done: got %0b expected 1", mif.write_ready);
            end
        end
        prev_done = (mif.write_done === 1'b1);
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if (c.act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write_ready"},  32'(mif.write_ready),  1);
        check({tag, "_writer_ready"}, 32'(mif.writer_ready), 0);
        check({tag, "_write_done"},   32'(mif.write_done),   0);
        check({tag, "_write_error"},  32'(mif.write_error),  0);
        check({tag, "_bram_wr_en"},   32'(bram_wr_en),       0);
        check({tag, "_bram_wr_addr"}, 32'(bram_wr_addr),     0);
        check({tag, "_bram_wr_data"}, 32'(bram_wr_data),     0);
    endtask

    // gap: 0 = continuous valid, 1 = alternate cycles, 2 = random
    // abort_after > 0: assert reset once that many beats have transferred
    task automatic run_txn(input int id, input int rows, input int cols, input logic [63:0] nm,
                           input int offered, input int gap, input int abort_after,
                           input bit seq_data);
        logic [DATA_WIDTH-1:0] stream[$];
        int  total, base, lim, j, n, done_n, cyc, w;
        bit  err, fire, got_done;
        wr_t e;

        for (int k = 0; k < offered; k++)
            stream.push_back(seq_data ? DATA_WIDTH'(k + 1) : DATA_WIDTH'($urandom));

        // Reference model of the expected BRAM image and completion status
        total = rows * cols;
        err   = (rows == 0) || (cols == 0) || (id >= int'(NUM_BLOCKS))
             || (total + int'(HDR_WORDS) > int'(BLOCK_SIZE));
        if (abort_after == 0) exp_done.push_back(err);
        if (!err) begin
            base = id * int'(BLOCK_SIZE);
            e.addr = ADDR_WIDTH'(base);     e.data = {8'(rows), 8'(cols), 16'h0}; exp_wr.push_back(e);
            e.addr = ADDR_WIDTH'(base + 1); e.data = nm[63:32];                   exp_wr.push_back(e);
            e.addr = ADDR_WIDTH'(base + 2); e.data = nm[31:0];                    exp_wr.push_back(e);
            lim = (abort_after > 0) ? abort_after : total;
            if (lim > offered) lim = offered;
            for (int k = 0; k < lim; k++) begin
                e.addr = ADDR_WIDTH'(base + int'(HDR_WORDS) + k);
                e.data = stream[k];
                exp_wr.push_back(e);
            end
        end

        @(negedge clk);
        mif.write_request = 1'b1;
        mif.matrix_id     = 3'(id);
        mif.actual_rows   = 8'(rows);
        mif.actual_cols   = 8'(cols);
        for (int i = 0; i < 8; i++) mif.matrix_name[i] = nm[63 - 8*i -: 8];
        w = 0;
        while (mif.write_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        mif.write_request = 1'b0;
        n = 1; j = 0; done_n = 0; got_done = 1'b0;

        for (cyc = 0; cyc < 5000; cyc++) begin
            if (mif.write_done === 1'b1) begin
                got_done = 1'b1;
                done_n   = n;
                break;
            end
            if (abort_after > 0 && j == abort_after) break;
            mif.data_valid = (j < offered) &&
                             ((gap == 0) || (gap == 1 && (cyc % 2) == 0) ||
                              (gap == 2 && $urandom_range(0, 1) == 1));
            mif.data_in    = (j < offered) ? stream[j] : '0;
            fire = mif.data_valid && (mif.writer_ready === 1'b1);
            @(posedge clk);
            if (fire) j++;
            @(negedge clk);
            n++;
        end

        if (abort_after > 0) begin
            mif.data_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("abort");
            check("abort_beats", 32'(j), 32'(abort_after));
            rst = 1'b0;
            return;
        end

        if (got_done && mif.writer_ready !== 1'b0) check("writer_ready_at_done", 32'(mif.writer_ready), 0);
        mif.data_valid = 1'b0;
        check("done_seen", 32'(got_done), 1);
        if (err) check("reject_latency", 32'(done_n), 2);
        lim = err ? 0 : ((total < offered) ? total : offered);
        check("beats_consumed", 32'(j), 32'(lim));
    endtask

    initial begin
        int r, c, id, off;
        logic [63:0] nm;
        rst               = 1'b1;
        mif.write_request = 1'b0;
        mif.matrix_id     = '0;
        mif.actual_rows   = '0;
        mif.actual_cols   = '0;
        for (int i = 0; i < 8; i++) mif.matrix_name[i] = '0;
        mif.data_in       = '0;
        mif.data_valid    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_txn(1, 3, 3, "CONV0000", 9, 0, 0, 1'b1);
        run_txn(1, 3, 3, "CONV0000", 9, 1, 0, 1'b1);
        run_txn(0, 0, 5, "ZEROROWS", 5, 0, 0, 1'b0);
        run_txn(2, 40, 40, "TOOBIG40", 4, 0, 0, 1'b0);
        run_txn(3, 32, 32, "EDGE3232", 4, 0, 0, 1'b0);
        run_txn(7, 31, 32, "LAST3132", 992, 0, 0, 1'b0);
        run_txn(4, 3, 3, "OVERFEED", 12, 0, 0, 1'b1);
        run_txn(5, 3, 3, "ABORTED!", 9, 0, 4, 1'b0);
        run_txn(6, 2, 2, "AFTERRST", 4, 0, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            r   = $urandom_range(0, 12);
            c   = $urandom_range(0, 12);
            id  = $urandom_range(0, 7);
            off = r * c + $urandom_range(0, 3);
            nm  = {$urandom, $urandom};
            run_txn(id, r, c, nm, off, $urandom_range(0, 2), 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("leftover_writes", 32'(exp_wr.size()), 0);
        check("leftover_dones",  32'(exp_done.size()), 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_result_writer.md
Name: matrix_result_writer

Overview:
Responder end of the matrix write interface driven by matrix operation units such as matrix_op_conv. It accepts a write request carrying matrix metadata, stores the metadata header and a row-major data stream into the matrix BRAM block selected by matrix_id, then pulses write_done. It sits between the operation units and the shared matrix BRAM write port.

Parameters:
BLOCK_SIZE, 1024, words per matrix block in BRAM
NUM_BLOCKS, 8, number of matrix blocks (valid matrix_id range 0..NUM_BLOCKS-1)
ADDR_WIDTH, 14, BRAM word-address width
DATA_WIDTH, 32, BRAM word / stream data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
write_request  in  1  initiator requests a write transaction
write_ready  out  1  high in IDLE; request accepted on write_request && write_ready
matrix_id  in  3  destination block, sampled at accept
actual_rows  in  8  matrix rows, sampled at accept
actual_cols  in  8  matrix cols, sampled at accept
matrix_name  in  8x8 (unpacked [0:7])  ASCII name bytes, sampled at accept
data_in  in  DATA_WIDTH  stream element
data_valid  in  1  data_in valid
writer_ready  out  1  beat transfers on data_valid && writer_ready
write_done  out  1  one-cycle pulse at end of transaction
write_error  out  1  valid with write_done; 1 = request rejected
bram_wr_en  out  1  BRAM write enable
bram_wr_addr  out  ADDR_WIDTH  BRAM write address
bram_wr_data  out  DATA_WIDTH  BRAM write data

Behaviour:
- Reset: state IDLE; write_ready=1; writer_ready, write_done, write_error, bram_wr_en = 0; bram_wr_addr, bram_wr_data, internal counters = 0. All outputs registered.
- Layout: base = matrix_id*BLOCK_SIZE. Header is MATRIX_METADATA_WORDS words (matrix_op_defs_pkg): word0 = {rows[7:0], cols[7:0], 16'd0}; word1 = {name[0],name[1],name[2],name[3]} (name[0] in MSB); word2 = {name[4]..name[7]}; any further header words = 0. Element k (0..rows*cols-1) at base+MATRIX_METADATA_WORDS+k.
- States: IDLE, CHECK, META, DATA, DONE.
- IDLE: on accept, latch id/rows/cols/name, write_ready->0 next cycle, go CHECK. write_request with write_ready low is ignored (never queued).
- CHECK (1 cycle): total = rows*cols (16-bit). Error if rows==0, cols==0, matrix_id>=NUM_BLOCKS, or total+MATRIX_METADATA_WORDS > BLOCK_SIZE -> DONE with error, no BRAM writes. Else -> META.
- META: one header word per cycle, bram_wr_en=1, addresses base..base+MATRIX_METADATA_WORDS-1 ascending; writer_ready=0 throughout. After the last header word -> DATA.
- DATA: writer_ready=1. Each transfer beat issues a BRAM write of data_in on the next cycle at the next element address (1-cycle write latency); beat counter increments. data_valid with writer_ready low is not a transfer and is not consumed. Gaps in data_valid are allowed; no write in gap cycles. On the cycle the final beat (count==total-1) transfers, writer_ready is driven 0 for the next cycle; beats after that are not accepted. -> DONE.
- DONE: write_done=1 for exactly one cycle, write_error per CHECK result (0 on success); next cycle write_ready=1, back to IDLE. A new request can be accepted on the first cycle back in IDLE.
- bram_wr_en is never high outside META and the cycle after a DATA beat.
- Reset mid-transaction: immediate return to IDLE next edge, no write_done, partially written BRAM contents are left as-is.
- write_request high during CHECK/META/DATA/DONE has no effect.

Test Plan:
- id=1, 3x3, name "CONV0000", stream 1..9 with data_valid continuous -> header writes at 1024,1025,1026 (word0=0x03030000), data 1..9 at 1024+MATRIX_METADATA_WORDS+0..8, write_done pulse with write_error=0, write_ready high next cycle.
- Same 3x3 with data_valid toggled 1/0 every cycle -> identical BRAM contents, exactly 9 data writes, no write during gaps.
- rows=0, cols=5 -> no bram_wr_en at all, write_done=1 and write_error=1 two cycles after accept.
- 40x40 (1600 > BLOCK_SIZE-MATRIX_METADATA_WORDS) -> rejected with write_error=1; 31x32 at id 7 accepted, last element at 7*1024+MATRIX_METADATA_WORDS+991.
- Source holds data_valid high with 12 words for a 3x3 -> only first 9 written, writer_ready low after 9th beat, words 10-12 not consumed.
- rst asserted after 4 of 9 data beats -> next edge outputs at reset values, no write_done; new 2x2 request then completes normally.
